// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between NUM_REQ byte requesters, the round-robin arbiter and one UART transmitter.
// The master modport is the arbiter's view; the slave modport is the requester/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 timeout;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, busy, timeout
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, busy, timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter byte port between NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to force release of an owner stalled for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] owner_inc;
    logic [ID_W-1:0] pick;
    logic            any_req;
    logic            owner_valid, owner_last;
    logic [7:0]      owner_data;
    logic            busy_int;
    logic            xfer;
    logic            stall_expired;
    int              idx;

    // Owner's request lines, muxed from the registered owner index.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    // First valid requester at or after rr_q with wrap; scanning downward lets the nearest one win.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[ID_W'(idx)]) begin
                any_req = 1'b1;
                pick    = ID_W'(idx);
            end
        end
    end

    assign owner_inc = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    // Outputs are masked during reset so nothing is accepted in the reset cycle itself.
    assign busy_int      = (state_q == LOCKED) && !reset;
    assign xfer          = busy_int && owner_valid && bus.tx_ready;
    assign bus.busy      = busy_int;
    assign bus.tx_valid  = busy_int && owner_valid;
    assign bus.tx_data   = owner_data;
    assign bus.grant_id  = owner_q;
    assign bus.req_ready = (busy_int && bus.tx_ready) ? (NUM_REQ'(1) << owner_q) : '0;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] stall_cnt_q;
    logic             timeout_q;

    assign stall_expired = (state_q == LOCKED) && !owner_valid &&
                           (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside LOCKED, so every lock starts with a cleared count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= stall_expired;
            if (state_q != LOCKED || owner_valid || stall_expired)
                stall_cnt_q <= '0;
            else
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign stall_expired = 1'b0;
    assign bus.timeout   = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = LOCKED;
                    owner_d = pick;
                end
            end
            LOCKED: begin
                if ((xfer && owner_last) || stall_expired) begin
                    state_d = IDLE;
                    rr_d    = owner_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues drive the DUT, a packet-level
// round-robin model predicts the transmitted byte order; directed tasks cover the corner cases.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 3;
    localparam int TO      = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } byte_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    byte_t      src_q[NUM_REQ][$];
    bit         first_b[NUM_REQ];
    int         sent[NUM_REQ];
    int         pause_at[NUM_REQ];
    int         pause_left[NUM_REQ];
    int         gap_pct;
    int         rdy_mode;     // 0: ready high, 1: random, 2: held low
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc;
    int         model_rr;

    int         obs_req[$];
    logic [7:0] obs_byte[$];
    int         obs_gid[$];
    int         obs_cyc[$];
    bit         obs_last[$];
    int         to_cyc[$];
    bit         busy_hist[$];
    bit         txv_hist[$];
    int         exp_req[$];
    logic [7:0] exp_byte[$];

    task automatic drive();
        logic [NUM_REQ-1:0]   v, l;
        logic [8*NUM_REQ-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() == 0) begin
                d[8*i +: 8] = 8'($urandom);
                l[i]        = 1'($urandom);
            end else begin
                d[8*i +: 8] = src_q[i][0].data;
                l[i]        = src_q[i][0].last;
                if (first_b[i]) v[i] = 1'b1;
                else if (pause_left[i] > 0 && sent[i] == pause_at[i]) begin
                    v[i] = 1'b0;
                    pause_left[i]--;
                end else v[i] = ($urandom_range(99) >= gap_pct);
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        case (rdy_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ($urandom_range(99) < 70);
            default: bus.tx_ready = 1'b0;
        endcase
    endtask

    task automatic flush_req(int r);
        src_q[r].delete();
        first_b[r]    = 1'b1;
        sent[r]       = 0;
        pause_at[r]   = -1;
        pause_left[r] = 0;
    endtask

    task automatic flush_all();
        for (int i = 0; i < NUM_REQ; i++) flush_req(i);
    endtask

    task automatic push_byte(int r, logic [7:0] d, logic l);
        byte_t b;
        b.data = d;
        b.last = l;
        src_q[r].push_back(b);
    endtask

    task automatic clear_obs();
        obs_req.delete(); obs_byte.delete(); obs_gid.delete(); obs_cyc.delete();
        obs_last.delete(); to_cyc.delete(); busy_hist.delete(); txv_hist.delete();
        exp_req.delete(); exp_byte.delete();
        cyc = 0;
    endtask

    // One clock: sample at the falling edge, retire accepted bytes and redrive after the rising edge.
    task automatic step();
        logic [NUM_REQ-1:0] hs;
        int w;
        @(negedge clk);
        cyc++;
        hs = bus.req_valid & bus.req_ready;
        busy_hist.push_back(bus.busy);
        txv_hist.push_back(bus.tx_valid);
        if (bus.timeout) to_cyc.push_back(cyc);
        n_vec++;
        if ($countones(hs) > 1 || ((bus.tx_valid && bus.tx_ready) !== (hs != '0))) begin
            n_err++;
            $display("FAIL handshake cyc %0d: req_valid&req_ready=%b tx_valid=%b tx_ready=%b",
                     cyc, hs, bus.tx_valid, bus.tx_ready);
        end
        w = -1;
        for (int i = 0; i < NUM_REQ; i++) if (hs[i]) w = i;
        if (w >= 0) begin
            obs_req.push_back(w);
            obs_byte.push_back(bus.tx_data);
            obs_gid.push_back(int'(bus.grant_id));
            obs_cyc.push_back(cyc);
            obs_last.push_back(src_q[w][0].last);
            n_vec++;
            if (bus.tx_data !== src_q[w][0].data) begin
                n_err++;
                $display("FAIL tx_data cyc %0d: got %h expected %h", cyc, bus.tx_data, src_q[w][0].data);
            end
        end
        @(posedge clk);
        #1;
        if (w >= 0) begin
            first_b[w] = src_q[w][0].last;
            sent[w]++;
            void'(src_q[w].pop_front());
        end
        drive();
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_until_empty(int budget);
        int n = 0;
        while (any_pending() && n < budget) begin
            step();
            n++;
        end
        n_vec++;
        if (any_pending()) begin
            n_err++;
            $display("FAIL drain budget: bytes still queued after %0d cycles, expected none", budget);
            flush_all();
            drive();
        end
        step();
        step();
    endtask

    // Packet-level round robin: whole packets leave in pointer order, skipping empty requesters.
    task automatic build_expected();
        byte_t cp[NUM_REQ][$];
        int p, w, j;
        bit l;
        for (int i = 0; i < NUM_REQ; i++) cp[i] = src_q[i];
        p = model_rr;
        while (1) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (p + k) % NUM_REQ;
                if (w < 0 && cp[j].size() > 0) w = j;
            end
            if (w < 0) break;
            do begin
                exp_req.push_back(w);
                exp_byte.push_back(cp[w][0].data);
                l = cp[w][0].last;
                void'(cp[w].pop_front());
            end while (!l && cp[w].size() > 0);
            p = (w + 1) % NUM_REQ;
        end
        model_rr = p;
    endtask

    task automatic compare_stream(string tag);
        int m;
        n_vec++;
        if (obs_byte.size() != exp_byte.size()) begin
            n_err++;
            $display("FAIL %s count: got %0d bytes expected %0d", tag, obs_byte.size(), exp_byte.size());
        end
        m = (obs_byte.size() < exp_byte.size()) ? obs_byte.size() : exp_byte.size();
        for (int k = 0; k < m; k++) begin
            n_vec++;
            if (obs_req[k] !== exp_req[k] || obs_gid[k] !== exp_req[k] || obs_byte[k] !== exp_byte[k]) begin
                n_err++;
                $display("FAIL %s byte %0d: got req %0d gid %0d data %h expected req %0d data %h",
                         tag, k, obs_req[k], obs_gid[k], obs_byte[k], exp_req[k], exp_byte[k]);
            end
            if (k > 0 && obs_last[k-1]) begin
                n_vec++;
                if (obs_cyc[k] < obs_cyc[k-1] + 2) begin
                    n_err++;
                    $display("FAIL %s spacing %0d: got cycle %0d expected >= %0d",
                             tag, k, obs_cyc[k], obs_cyc[k-1] + 2);
                end
            end
        end
    endtask

    task automatic expect_int(string tag, int got, int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_all();
        gap_pct  = 0;
        rdy_mode = 0;
        drive();
        step();
        step();
        reset    = 1'b0;
        model_rr = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush_all();
        gap_pct  = 0;
        rdy_mode = 0;
        push_byte(1, 8'hA5, 1'b1);
        drive();
        repeat (2) begin
            @(negedge clk);
            expect_int("reset busy", int'(bus.busy), 0);
            expect_int("reset tx_valid", int'(bus.tx_valid), 0);
            expect_int("reset req_ready", int'(bus.req_ready), 0);
            expect_int("reset timeout", int'(bus.timeout), 0);
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        model_rr = 0;
        clear_obs();
        build_expected();
        run_until_empty(20);
        compare_stream("reset_release");
        expect_int("reset idle busy", int'(busy_hist[0]), 0);
    endtask

    task automatic test_single_packet();
        do_reset();
        clear_obs();
        push_byte(0, 8'h48, 1'b0);
        push_byte(0, 8'h69, 1'b0);
        push_byte(0, 8'h0A, 1'b1);
        build_expected();
        drive();
        run_until_empty(50);
        compare_stream("single");
        if (obs_cyc.size() == 3) begin
            expect_int("single first latency", obs_cyc[0], 2);
            expect_int("single last cycle", obs_cyc[2], 4);
        end
        expect_int("single busy during", int'(busy_hist[1] & busy_hist[2] & busy_hist[3]), 1);
        expect_int("single busy after last", int'(busy_hist[4]), 0);
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_obs();
        push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
        push_byte(1, 8'h44, 1'b0); push_byte(1, 8'h55, 1'b1);
        build_expected();
        drive();
        run_until_empty(50);
        compare_stream("rr_pair");
        if (obs_cyc.size() == 5) expect_int("rr second packet start", obs_cyc[3], 6);
        // Pointer now sits past requester 1, so requester 2 outranks requester 0.
        clear_obs();
        push_byte(0, 8'h60, 1'b1);
        push_byte(2, 8'h62, 1'b1);
        build_expected();
        drive();
        run_until_empty(50);
        compare_stream("rr_pointer");
    endtask

    task automatic test_hold_lock();
        int p;
`ifdef UART_ARB_TIMEOUT_EN
        p = 10;
`else
        p = 50;
`endif
        do_reset();
        clear_obs();
        for (int k = 0; k < 4; k++) push_byte(0, 8'hB0 + 8'(k), k == 3);
        push_byte(1, 8'hC0, 1'b0); push_byte(1, 8'hC1, 1'b1);
        pause_at[0]   = 1;
        pause_left[0] = p;
        build_expected();
        drive();
        run_until_empty(200);
        compare_stream("hold_lock");
        if (obs_cyc.size() == 6) expect_int("hold_lock gap", obs_cyc[1] - obs_cyc[0], p + 1);
    endtask

    task automatic test_tx_stall();
        int bad = 0;
        do_reset();
        clear_obs();
        push_byte(0, 8'h55, 1'b1);
        rdy_mode = 2;
        build_expected();
        drive();
        step();
        for (int n = 0; n < 1085; n++) begin
            if (bus.req_ready !== '0 || bus.tx_data !== 8'h55 || bus.tx_valid !== 1'b1) bad++;
            step();
        end
        expect_int("stall bad cycles", bad, 0);
        expect_int("stall transfers", obs_byte.size(), 0);
        rdy_mode = 0;
        drive();
        run_until_empty(20);
        compare_stream("stall_release");
        if (obs_cyc.size() == 1) expect_int("stall release cycle", obs_cyc[0], 1087);
        expect_int("stall busy after", int'(busy_hist[1087]), 0);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        clear_obs();
        push_byte(0, 8'hAA, 1'b0); push_byte(0, 8'hBB, 1'b0);
        push_byte(0, 8'hCC, 1'b0); push_byte(0, 8'hDD, 1'b1);
        drive();
        step();
        step();
        reset = 1'b1;
        step();
        expect_int("midreset accepted bytes", obs_byte.size(), 1);
        reset    = 1'b0;
        model_rr = 0;
        clear_obs();
        flush_req(0);
        push_byte(1, 8'h77, 1'b1);
        push_byte(0, 8'h66, 1'b1);
        build_expected();
        drive();
        step();
        expect_int("midreset busy after", int'(busy_hist[0]), 0);
        expect_int("midreset tx_valid after", int'(txv_hist[0]), 0);
        run_until_empty(50);
        compare_stream("midreset_after");
    endtask

    task automatic test_timeout();
        do_reset();
        clear_obs();
        push_byte(0, 8'hE0, 1'b0); push_byte(0, 8'hE1, 1'b0); push_byte(0, 8'hE2, 1'b1);
        push_byte(1, 8'hD0, 1'b0); push_byte(1, 8'hD1, 1'b1);
        pause_at[0]   = 1;
        pause_left[0] = 40;
`ifdef UART_ARB_TIMEOUT_EN
        exp_req  = '{0, 1, 1};
        exp_byte = '{8'hE0, 8'hD0, 8'hD1};
        model_rr = 2;
        drive();
        repeat (19) step();
        flush_req(0);
        drive();
        run_until_empty(50);
        compare_stream("timeout");
        expect_int("timeout pulses", to_cyc.size(), 1);
        if (to_cyc.size() > 0) expect_int("timeout cycle", to_cyc[0], 19);
        expect_int("timeout busy drop", int'(busy_hist[18]), 0);
        if (obs_cyc.size() == 3) expect_int("timeout regrant cycle", obs_cyc[1], 20);
`else
        build_expected();
        drive();
        run_until_empty(200);
        compare_stream("no_timeout");
        expect_int("no_timeout pulses", to_cyc.size(), 0);
        expect_int("no_timeout lock held", int'(busy_hist[18]), 1);
        if (obs_cyc.size() == 5) expect_int("no_timeout resume cycle", obs_cyc[1], 43);
`endif
    endtask

    task automatic test_random();
        int npk, len;
        do_reset();
        gap_pct  = 25;
        rdy_mode = 1;
        for (int round = 0; round < 25; round++) begin
            clear_obs();
            for (int i = 0; i < NUM_REQ; i++) begin
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) push_byte(i, 8'($urandom), k == len - 1);
                end
            end
            build_expected();
            drive();
            run_until_empty(2000);
            compare_stream("random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_hold_lock();
        test_tx_stall();
        test_reset_mid_packet();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares one UART transmitter byte port between NUM_REQ requesters, e.g. CPU console, debug dump and bootloader echo.
- Sits directly upstream of the transmitter. It drives the transmitter's byte/valid inputs and consumes its ready output.
- A grant is held from a requester's first byte through its byte marked last, so packets never interleave on the serial line.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1_000_000, stall limit used only when UART_ARB_TIMEOUT_EN is defined.
- ID_W, $clog2(NUM_REQ) (min 1), width of the grant index.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester byte valid
- req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
- req_last  input  NUM_REQ  byte is final byte of the requester's packet
- req_ready  output  NUM_REQ  per-requester byte accepted this cycle
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  byte valid to transmitter
- tx_ready  input  1  transmitter ready for a byte
- grant_id  output  ID_W  index of current owner (valid while busy)
- busy  output  1  a requester holds the grant
- timeout  output  1  one-cycle pulse on forced release

Behaviour:
- States: IDLE, LOCKED. Registered state: owner index, round-robin pointer rr_ptr, stall counter.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, busy=0, tx_valid=0, req_ready=0, timeout=0, counter=0.
- Reset is honoured in any state, including mid-packet. The current packet is abandoned and no byte is accepted in the reset cycle.
- IDLE arbitration:
  - If any req_valid is high, select the first set bit at or after rr_ptr, scanning upward with wrap (rr_ptr, rr_ptr+1, ... NUM_REQ-1, 0, ...).
  - Register it as owner and go to LOCKED at the next edge.
  - No byte is transferred in IDLE.
- LOCKED outputs (combinational from registered owner):
  - busy=1
  - tx_valid = req_valid[owner]
  - tx_data = req_data[owner]
  - req_ready[i] = (i==owner) & tx_ready
  - All other req_ready bits are 0.
- Transfer occurs on a cycle with tx_valid & tx_ready.
- Transfer with req_last[owner]=1: go to IDLE next cycle and set rr_ptr = owner+1 (wrap to 0 past NUM_REQ-1).
- Latency and spacing:
  - Request rising in IDLE in cycle N: tx_valid at earliest in cycle N+1.
  - Packets are separated by at least one IDLE cycle.
- Lock is held while the owner deasserts req_valid mid-packet. Other requesters wait.
- req_valid from non-owners is ignored while LOCKED and may change freely.
- tx_data/tx_valid follow the owner's inputs directly. Stability under tx_ready=0 is the requester's obligation; the arbiter adds no buffering.
- A single-byte packet (last on first byte) is legal: LOCKED for exactly the cycles until that transfer.
- grant_id holds its last value in IDLE; it is meaningful only while busy=1.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - In LOCKED, the counter increments each cycle with req_valid[owner]=0.
  - The counter clears on any cycle with req_valid[owner]=1, and on entry to LOCKED.
  - When the counter reaches TIMEOUT_CYCLES-1 while still stalled: pulse timeout=1 for one cycle, return to IDLE, set rr_ptr = owner+1, clear the counter.
- Not defined: no counter logic; timeout tied to 0; lock is held indefinitely until last.

Test Plan:
- Only req 0 sends 0x48,0x69,0x0A (last on 0x0A), tx_ready always 1 -> tx_data sequence 0x48,0x69,0x0A; busy falls the cycle after 0x0A; grant_id=0.
- req 0 and req 1 both assert packets in the same cycle from reset -> req 0 packet fully sent first, then req 1; rr_ptr ends at 0.
- req 0 mid-packet drops valid for 50 cycles while req 1 is valid -> no req 1 byte accepted until req 0 sends its last byte; grant_id stays 0.
- tx_ready held 0 for 1085 cycles with owner byte 0x55 valid -> req_ready stays 0, tx_data=0x55 throughout; exactly one transfer when tx_ready rises.
- reset pulsed during byte 2 of a 4-byte packet -> next cycle busy=0, tx_valid=0, rr_ptr=0; remaining bytes are not sent.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner stalls after byte 1 -> timeout pulses once 16 stalled cycles after the stall begins, then busy=0, and the other pending requester is granted next. Without the macro the same stimulus keeps the lock and timeout stays 0.
